// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

    // Transmitter states, in transfer order.
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_t;

    // Codes reported on err_code together with the err pulse.
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;
    localparam logic [1:0] ERR_XFER_TO  = 2'd3;

    // Frequently used device commands.
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;

    // Width of the saturating timeout counter.
    localparam int TO_W = 20;

    // Odd parity bit that completes a PS/2 frame for the given byte.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a clock
// falling-edge detector. Shared with the receive path.
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic clk_p0;
    logic clk_p1;
    logic clk_p2;
    logic data_p0;
    logic data_p1;

    // Synchronizer chains; reset to the idle (released, high) line level so
    // no spurious edge is seen when reset is lifted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_p0  <= 1'b1;
            clk_p1  <= 1'b1;
            clk_p2  <= 1'b1;
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
        end else begin
            // stage p0 -> p1: metastability settling
            clk_p0  <= clk_in;
            data_p0 <= data_in;
            // stage p1 -> p2: previous synchronized clock for edge detection
            clk_p1  <= clk_p0;
            data_p1 <= data_p0;
            clk_p2  <= clk_p1;
        end
    end

    assign clk_sync  = clk_p1;
    assign data_sync = data_p1;
    assign clk_fe    = clk_p2 & ~clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, requests to
// send, shifts out start/data/parity/stop on device clock falling edges,
// then reports ACK (done), NACK or timeout (err + err_code).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 65_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_MS = 15,
    parameter int XFER_TO_MS  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // Cycle counts derived from the clock frequency.
    localparam int INH_CYC      = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int DATA_LEAD    = 65;
    localparam int DATA_ON_AT   = INH_CYC - DATA_LEAD - 1;
    localparam int INH_W        = $clog2(INH_CYC);
    localparam int START_TO_CYC = (CLK_HZ / 1000) * START_TO_MS;
    localparam int XFER_TO_CYC  = (CLK_HZ / 1000) * XFER_TO_MS;

    localparam logic [INH_W-1:0] INH_LAST     = INH_W'(INH_CYC - 1);
    localparam logic [INH_W-1:0] INH_DATA_ON  = INH_W'(DATA_ON_AT);
    localparam logic [TO_W-1:0]  START_TO_LIM = TO_W'(START_TO_CYC - 1);
    localparam logic [TO_W-1:0]  XFER_TO_LIM  = TO_W'(XFER_TO_CYC - 1);

    // Timeout counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ps2_tx_state_t    state_q, state_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [8:0]       shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             ack_ok_q, ack_ok_d;

    logic clk_sync;
    logic data_sync;
    logic clk_fe;
    logic start_to;
    logic xfer_to;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fe    (clk_fe)
    );

    assign start_to = (to_cnt_q >= START_TO_LIM);
    assign xfer_to  = (to_cnt_q >= XFER_TO_LIM);

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // Next-state, line-enable and status logic; a timeout always takes
    // priority over a clock edge seen in the same cycle.
    always_comb begin
        state_d    = state_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = sat_inc(to_cnt_q);
        ack_ok_d   = ack_ok_q;

        unique case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    shreg_d   = {odd_parity(tx_data), tx_data};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                // Pull data low shortly before releasing the clock.
                if (inh_cnt_q >= INH_DATA_ON) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = REQ;
                end
            end

            REQ: begin
                if (start_to) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_START_TO;
                    state_d    = IDLE;
                end else if (clk_fe) begin
                    // Device has started clocking; the transfer window begins.
                    to_cnt_d = '0;
                    state_d  = SEND;
                end
            end

            SEND: begin
                if (xfer_to) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_XFER_TO;
                    state_d    = IDLE;
                end else if (clk_fe) begin
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            ACK: begin
                if (xfer_to) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_XFER_TO;
                    state_d    = IDLE;
                end else if (clk_fe) begin
                    ack_ok_d = ~data_sync;
                    state_d  = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (xfer_to) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = ERR_XFER_TO;
                    state_d    = IDLE;
                end else if (clk_sync && data_sync) begin
                    if (ack_ok_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_NACK;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // Control state register; reset releases both lines immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ack_ok_q   <= ack_ok_d;
        end
    end

    // Frame shift register; contents are only meaningful once loaded.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device and a
// bit-level scoreboard of the serialized frame.
module tb_ps2_host_tx;

    localparam int CLK_HZ       = 1_000_000;
    localparam int INHIBIT_US   = 100;
    localparam int START_TO_MS  = 15;
    localparam int XFER_TO_MS   = 2;
    localparam int INH_CYC      = 100;
    localparam int START_TO_CYC = 15000;
    localparam int XFER_TO_CYC  = 2000;
    localparam int HALF         = 40;   // 12.5 kHz device clock at 1 MHz

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_data_low = 1'b0;
    logic       clk_line, data_line;

    // Open-drain bus with pull-ups: either side pulling low wins.
    assign clk_line  = ~(ps2_clk_oe | bfm_clk_low);
    assign data_line = ~(ps2_data_oe | bfm_data_low);

    ps2_host_tx #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_US  (INHIBIT_US),
        .START_TO_MS (START_TO_MS),
        .XFER_TO_MS  (XFER_TO_MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_q[$];
    logic smp [1:11];

    // Event monitor: pulse counts, pulse widths, inhibit length, timing.
    int         cyc = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] last_code = 2'd0;
    int         err_cyc = 0;
    int         req_cyc = 0;
    int         clk_oe_run = 0;
    int         clk_oe_last = 0;
    logic       prev_clk_oe = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_err = 1'b0;
    logic       both_seen = 1'b0;
    logic       wide_pulse = 1'b0;
    int         fe_pad_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) begin
            err_cnt   <= err_cnt + 1;
            last_code <= err_code;
            err_cyc   <= cyc;
        end
        if (done === 1'b1 && err === 1'b1) both_seen <= 1'b1;
        if ((done === 1'b1 && prev_done) || (err === 1'b1 && prev_err)) wide_pulse <= 1'b1;
        prev_done <= (done === 1'b1);
        prev_err  <= (err === 1'b1);
        if (ps2_clk_oe === 1'b1) clk_oe_run <= clk_oe_run + 1;
        else if (clk_oe_run != 0) begin
            clk_oe_last <= clk_oe_run;
            clk_oe_run  <= 0;
        end
        if (ps2_clk_oe === 1'b0 && prev_clk_oe) req_cyc <= cyc;
        prev_clk_oe <= (ps2_clk_oe === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for a single cycle; optionally queue its frame bits.
    task automatic send(input logic [7:0] d, input bit push);
        tx_data  = d;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        check("accept_ready_low", tx_ready, 1'b0);
        check("accept_clk_oe", ps2_clk_oe, 1'b1);
        if (push) begin
            exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
            exp_q.push_back(~^d);
            exp_q.push_back(1'b1);
        end
    endtask

    // Device model: waits for the request-to-send, then generates nclk
    // clocks, sampling host data on rising edges and optionally ACKing.
    task automatic bfm_run(input int nclk, input bit ack, input bit chk);
        int   t;
        logic e;
        t = 0;
        while (!(clk_line === 1'b1 && data_line === 1'b0) && t < 2 * INH_CYC + 20) begin
            step(1);
            t++;
        end
        check("bfm_request_seen", (clk_line === 1'b1 && data_line === 1'b0), 1'b1);
        step(HALF);
        for (int k = 1; k <= nclk; k++) begin
            bfm_clk_low = 1'b1;
            if (k == 1) fe_pad_cyc = cyc;
            step(HALF);
            bfm_clk_low = 1'b0;
            if (k <= 11) begin
                smp[k] = data_line;
                if (chk) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
                    check($sformatf("frame_bit%0d", k), data_line, e);
                end
            end
            if (k == 11 && ack) bfm_data_low = 1'b1;
            if (k == 12) bfm_data_low = 1'b0;
            step(HALF);
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0, input int budget);
        int t;
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < budget) begin
            step(1);
            t++;
        end
        step(4);
    endtask

    initial begin
        int d0, e0;

        // Reset state.
        step(3);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        rst = 1'b1;
        step(3);

        // 0xF4 with ACK, plus a request presented while busy.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b1);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step(3);
        check("busy_ready_low", tx_ready, 1'b0);
        check("busy_flag", busy, 1'b1);
        tx_valid = 1'b0;
        bfm_run(12, 1'b1, 1'b1);
        wait_outcome(d0, e0, 200);
        check("f4_done_cnt", done_cnt - d0, 1);
        check("f4_err_cnt", err_cnt - e0, 0);
        check("f4_inhibit_len", clk_oe_last, INH_CYC);
        check("f4_parity", smp[10], 1'b0);
        check("f4_sb_empty", exp_q.size(), 0);
        check("f4_clk_oe_rel", ps2_clk_oe, 1'b0);
        check("f4_data_oe_rel", ps2_data_oe, 1'b0);
        step(10);
        check("ignored_not_queued", busy, 1'b0);

        // 0x00 then 0xFF, both parity 1.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 1'b1);
        bfm_run(12, 1'b1, 1'b1);
        wait_outcome(d0, e0, 200);
        check("x00_done_cnt", done_cnt - d0, 1);
        check("x00_parity", smp[10], 1'b1);
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF, 1'b1);
        bfm_run(12, 1'b1, 1'b1);
        wait_outcome(d0, e0, 200);
        check("xff_done_cnt", done_cnt - d0, 1);
        check("xff_parity", smp[10], 1'b1);

        // NACK from the device.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF, 1'b1);
        bfm_run(12, 1'b0, 1'b1);
        wait_outcome(d0, e0, 200);
        check("nack_err_cnt", err_cnt - e0, 1);
        check("nack_code", last_code, 2'd1);
        check("nack_done_cnt", done_cnt - d0, 0);
        check("nack_clk_oe", ps2_clk_oe, 1'b0);
        check("nack_data_oe", ps2_data_oe, 1'b0);

        // Device never clocks: start timeout.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b0);
        wait_outcome(d0, e0, START_TO_CYC + INH_CYC + 200);
        check("sto_err_cnt", err_cnt - e0, 1);
        check("sto_code", last_code, 2'd2);
        check_range("sto_delay", err_cyc - req_cyc, START_TO_CYC - 1, START_TO_CYC + 1);
        check("sto_clk_oe", ps2_clk_oe, 1'b0);
        check("sto_data_oe", ps2_data_oe, 1'b0);

        // Device stops after 5 clocks: transfer timeout, then a clean retry.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b0);
        bfm_run(5, 1'b0, 1'b0);
        wait_outcome(d0, e0, XFER_TO_CYC + 200);
        check("xto_err_cnt", err_cnt - e0, 1);
        check("xto_code", last_code, 2'd3);
        check_range("xto_delay", err_cyc - fe_pad_cyc, XFER_TO_CYC + 2, XFER_TO_CYC + 4);
        check("xto_clk_oe", ps2_clk_oe, 1'b0);
        check("xto_data_oe", ps2_data_oe, 1'b0);
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b1);
        bfm_run(12, 1'b1, 1'b1);
        wait_outcome(d0, e0, 200);
        check("retry_done_cnt", done_cnt - d0, 1);
        check("retry_err_cnt", err_cnt - e0, 0);

        // Reset in the middle of SEND.
        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4, 1'b0);
        bfm_run(3, 1'b0, 1'b0);
        check("pre_rst_data_oe", ps2_data_oe, 1'b1);
        rst = 1'b0;
        step(1);
        check("mid_rst_clk_oe", ps2_clk_oe, 1'b0);
        check("mid_rst_data_oe", ps2_data_oe, 1'b0);
        step(2);
        rst = 1'b1;
        step(3);
        check("post_rst_ready", tx_ready, 1'b1);
        step(20);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_no_err", err_cnt - e0, 0);

        check("never_both", both_seen, 1'b0);
        check("single_cycle_pulses", wide_pulse, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
